// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures per-lane PWM high time over a 2^DWIDTH window after an hsync rise
// and replays the recovered duty values as a framed byte stream.
module pwm_capture #(
   parameter int STAGE    = 8,
   parameter int DWIDTH   = 8,
   parameter int DATA_DIV = 32
) (
   input  logic              clkforcounter,
   input  logic              rst,
   input  logic              hsync,
   input  logic [0:STAGE-1]  pwm_in,
   output logic [DWIDTH-1:0] data,
   output logic              start,
   output logic              valid,
   output logic              busy,
   output logic [0:STAGE-1]  ovf
);

   localparam int SW = (STAGE > 1) ? $clog2(STAGE) : 1;
   localparam int VW = (DATA_DIV > 1) ? $clog2(DATA_DIV) : 1;
   localparam logic [DWIDTH-1:0] CNT_MAX  = '1;
   localparam logic [SW-1:0]     SLOT_END = SW'(STAGE - 1);
   localparam logic [VW-1:0]     DIV_END  = VW'(DATA_DIV - 1);

   typedef enum logic [1:0] {IDLE, MEASURE, SEND} state_t;

   state_t            state_q, state_d;
   logic              hsync_q;
   logic [DWIDTH-1:0] win_q, win_d;
   logic [SW-1:0]     slot_q, slot_d;
   logic [VW-1:0]     div_q, div_d;
   logic [DWIDTH-1:0] cnt_q [STAGE];
   logic [DWIDTH-1:0] cnt_d [STAGE];
   logic [0:STAGE-1]  ovf_q, ovf_d;
   logic [DWIDTH-1:0] data_q, data_d;
   logic              start_q, start_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              rise;

   assign rise = hsync & ~hsync_q;

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      slot_d  = slot_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      data_d  = data_q;
      start_d = start_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = MEASURE;
               win_d   = '0;
               ovf_d   = '0;
               busy_d  = 1'b1;
               for (int k = 0; k < STAGE; k++) cnt_d[k] = '0;
            end
         end
         MEASURE: begin
            for (int k = 0; k < STAGE; k++) begin
               if (pwm_in[k]) begin
                  if (cnt_q[k] == CNT_MAX) ovf_d[k] = 1'b1;
                  else                     cnt_d[k] = cnt_q[k] + 1'b1;
               end
            end
            win_d = win_q + 1'b1;
            // Slot 0 is loaded from the post-sample count so it lands with the last sample.
            if (win_q == CNT_MAX) begin
               state_d = SEND;
               slot_d  = '0;
               div_d   = '0;
               data_d  = cnt_d[0];
               start_d = 1'b1;
               valid_d = 1'b1;
            end
         end
         SEND: begin
            div_d = div_q + 1'b1;
            if (div_q == DIV_END) begin
               div_d   = '0;
               start_d = 1'b0;
               if (slot_q == SLOT_END) begin
                  state_d = IDLE;
                  data_d  = '0;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  slot_d = slot_q + 1'b1;
                  data_d = cnt_q[slot_d];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clkforcounter) begin
      if (rst) begin
         state_q <= IDLE;
         hsync_q <= 1'b0;
         win_q   <= '0;
         slot_q  <= '0;
         div_q   <= '0;
         ovf_q   <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         for (int k = 0; k < STAGE; k++) cnt_q[k] <= '0;
      end else begin
         state_q <= state_d;
         hsync_q <= hsync;
         win_q   <= win_d;
         slot_q  <= slot_d;
         div_q   <= div_d;
         ovf_q   <= ovf_d;
         data_q  <= data_d;
         start_q <= start_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign data  = data_q;
   assign start = start_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign ovf   = ovf_q;

endmodule
